d8_alu_sched: RTL and testbench
===============================

// Module: d8_alu_sched
// PURPOSE
// - Shares the single d8 ALU between two requesters: 0 = core issue, 1 = debug/monitor port.
// - Round-robin arbitration; drives ALU op/operands; waits ALU_LAT cycles; returns the writeback value.
// - Writeback select: ops 8'h01..8'h04 return the ALU result s. All other ops are bypass and return operand b.
// - Sits between issue logic and the ALU/output-mux pair; sequences every ALU use in the core.
// PARAMETERS
// - ALU_LAT  1   cycles from alu_op/alu_a/alu_b stable to alu_s valid; legal 1..15.
// - CNT_W    16  width of the grant counters; used only with D8_ALU_SCHED_STATS_EN.
// PORTS
// - sys_clk         in   1      single clock, rising edge.
// - sys_rst         in   1      reset, asynchronous, active-high.
// - req0_valid      in   1      requester 0 has an op.
// - req0_ready      out  1      requester 0 accepted this cycle (valid & ready).
// - req0_op         in   8      opcode from requester 0.
// - req0_a          in   8      operand a from requester 0.
// - req0_b          in   8      operand b from requester 0.
// - req1_valid, req1_ready, req1_op, req1_a, req1_b   same as port 0, for requester 1.
// - alu_op          out  8      registered opcode to the ALU.
// - alu_a           out  8      registered operand a to the ALU.
// - alu_b           out  8      registered operand b to the ALU.
// - alu_s           in   8      ALU result.
// - rsp_valid       out  1      response available.
// - rsp_ready       in   1      consumer takes the response.
// - rsp_data        out  8      writeback value.
// - rsp_id          out  1      requester that owns the response.
// - busy            out  1      state != IDLE.
// - grant_cnt0      out  CNT_W  requester 0 grant count; present only with the macro.
// - grant_cnt1      out  CNT_W  requester 1 grant count; present only with the macro.
// BEHAVIOUR
// - Reset: every output is 0, state = IDLE, rr_ptr = 0 (requester 0 has priority). Reset acts immediately, in any state.
// - FSM states: IDLE, EXEC, RESP.
//   - IDLE: grant is combinational.
//     - Only one valid: that requester wins.
//     - Both valid: the requester selected by rr_ptr wins.
//     - reqN_ready = (state == IDLE) & winner == N. Only the winner sees ready.
//   - Accept at edge T:
//     - Latch op/a/b into alu_*; latch the winner into rsp_id.
//     - rr_ptr is set to the requester that did NOT win.
//     - ALU op (8'h01..8'h04): go to EXEC, cnt = ALU_LAT-1.
//     - Bypass op: go to RESP; rsp_data = b; rsp_valid = 1 at T+1.
//   - EXEC: when cnt == 0, rsp_data <= alu_s, rsp_valid <= 1, go to RESP; otherwise cnt decrements.
//     - Latency from accept to rsp_valid: ALU op = ALU_LAT+1 cycles; bypass = 1 cycle.
//   - RESP: rsp_valid, rsp_data and rsp_id hold stable until rsp_valid & rsp_ready.
//     - On that edge: rsp_valid <= 0, go to IDLE.
//     - No new grant is given in the same cycle. Minimum issue interval: bypass = 2 cycles, ALU op = ALU_LAT+2 cycles.
// - alu_* hold their last value while IDLE and RESP; they change only on an accept.
// - A requester that drops valid before it is granted loses nothing; no state is recorded for it.
// - Reset during EXEC/RESP: the op in flight and its response are discarded; no rsp_valid for it after reset.
// - Opcode 8'h00 and opcodes >= 8'h05 are bypass, with no special cases.
// CONFIGURATION
// - D8_ALU_SCHED_STATS_EN defined:
//   - grant_cnt0/1 exist. Each increments by 1 on its requester's accept.
//   - Counters saturate at all-ones and never wrap. Reset value is 0.
// - D8_ALU_SCHED_STATS_EN undefined:
//   - Counter ports and logic are absent. Every other behaviour and all timing are identical.
// TESTING (bench ALU model: s = a+b for 01, a-b for 02, a&b for 03, a|b for 04; ALU_LAT=1)
// - req0 op=01 a=03 b=05, accepted at T -> alu_op=01 at T+1; rsp_valid at T+2 with rsp_data=08, rsp_id=0.
// - req1 op=10 a=FF b=AA -> rsp_valid 1 cycle after accept, rsp_data=AA, rsp_id=1; EXEC is never entered.
// - Both valid continuously with op=03, rsp_ready=1 -> grants alternate 0,1,0,1; first grant goes to 0 after reset.
// - rsp_ready held 0 for 3 cycles with a response pending -> rsp_valid/data/id stable; req*_ready stays 0; release -> IDLE next cycle.
// - ALU_LAT=4, op=02 a=09 b=04 -> rsp_data=05 exactly 5 cycles after accept.
// - sys_rst pulsed during EXEC -> all outputs 0 at once; no stale response; next req0 op=04 a=F0 b=0F -> rsp_data=FF.
// - STATS_EN with CNT_W=2, 5 grants to requester 0 -> grant_cnt0 reads 3 (saturated); grant_cnt1 reads 0.

Source files
------------

// File: rtl/d8_alu_sched.sv
// d8_alu_sched: shares the single d8 ALU between core issue (requester 0)
// and the debug/monitor port (requester 1). Round-robin grant in IDLE,
// ALU_LAT-cycle wait in EXEC, response held in RESP until taken.
// Optional grant counters are enabled by defining D8_ALU_SCHED_STATS_EN.
module d8_alu_sched #(
   parameter int ALU_LAT = 1
`ifdef D8_ALU_SCHED_STATS_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [7:0]       req0_op,
   input  logic [7:0]       req0_a,
   input  logic [7:0]       req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [7:0]       req1_op,
   input  logic [7:0]       req1_a,
   input  logic [7:0]       req1_b,
   output logic [7:0]       alu_op,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   input  logic [7:0]       alu_s,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic             rsp_id,
   output logic             busy
`ifdef D8_ALU_SCHED_STATS_EN
   , output logic [CNT_W-1:0] grant_cnt0
   , output logic [CNT_W-1:0] grant_cnt1
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   state_t     state;
   logic       rr_ptr;
   logic [3:0] cnt;
   logic       win;
   logic       accept;
   logic       sel_alu;
   logic [7:0] sel_op, sel_a, sel_b;

   // Grant: a lone requester wins; on contention rr_ptr picks the winner.
   // Ready is masked during reset so every output reads 0 while it is held.
   always_comb begin
      win     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
      accept  = (state == IDLE) && (req0_valid || req1_valid) && !sys_rst;
      sel_op  = win ? req1_op : req0_op;
      sel_a   = win ? req1_a  : req0_a;
      sel_b   = win ? req1_b  : req0_b;
      sel_alu = (sel_op != 8'h00) && (sel_op <= 8'h04);
   end

   assign req0_ready = accept && !win;
   assign req1_ready = accept && win;
   assign busy       = (state != IDLE);

   // Sequencer: accept -> (EXEC wait) -> RESP hold -> IDLE.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         cnt       <= 4'd0;
         alu_op    <= 8'h00;
         alu_a     <= 8'h00;
         alu_b     <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
         rsp_id    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               alu_op <= sel_op;
               alu_a  <= sel_a;
               alu_b  <= sel_b;
               rsp_id <= win;
               rr_ptr <= ~win;
               if (sel_alu) begin
                  state <= EXEC;
                  cnt   <= LAT_M1;
               end else begin
                  state     <= RESP;
                  rsp_data  <= sel_b;
                  rsp_valid <= 1'b1;
               end
            end
            EXEC: if (cnt == 4'd0) begin
               rsp_data  <= alu_s;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end else begin
               cnt <= cnt - 4'd1;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef D8_ALU_SCHED_STATS_EN
   // Per-requester grant counters, saturating at all-ones.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (req0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
         if (req1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_d8_alu_sched.sv
// Scoreboard bench for d8_alu_sched: accepted requests push their expected
// writeback; a negedge monitor checks grants, ALU drive, latency and data.
module tb_d8_alu_sched;
   localparam int LAT = 3;
   localparam int CW  = 2;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0] req0_op, req0_a, req0_b, req1_op, req1_a, req1_b;
   logic [7:0] alu_op, alu_a, alu_b, alu_s;
   logic       rsp_valid, rsp_ready, rsp_id, busy;
   logic [7:0] rsp_data;
`ifdef D8_ALU_SCHED_STATS_EN
   logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

   d8_alu_sched #(
      .ALU_LAT(LAT)
`ifdef D8_ALU_SCHED_STATS_EN
      , .CNT_W(CW)
`endif
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
`ifdef D8_ALU_SCHED_STATS_EN
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   // Bench ALU; non-ALU opcodes produce junk so a wrong capture shows up.
   always_comb begin
      case (alu_op)
         8'h01:   alu_s = alu_a + alu_b;
         8'h02:   alu_s = alu_a - alu_b;
         8'h03:   alu_s = alu_a & alu_b;
         8'h04:   alu_s = alu_a | alu_b;
         default: alu_s = alu_a ^ 8'h5A;
      endcase
   end

   typedef struct {logic id; logic [7:0] data; int due;} exp_t;
   exp_t q[$];
   int errors = 0, checks = 0, ncyc = 0;
   int gcnt0 = 0, gcnt1 = 0;
   logic last_win = 1'b1;
   logic [7:0] l_op = 0, l_a = 0, l_b = 0;

   function automatic logic [7:0] ref_wb(logic [7:0] op, a, b);
      case (op)
         8'h01:   return a + b;
         8'h02:   return a - b;
         8'h03:   return a & b;
         8'h04:   return a | b;
         default: return b;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   task automatic push(logic id, logic [7:0] op, a, b);
      exp_t e;
      e.id   = id;
      e.data = ref_wb(op, a, b);
      e.due  = ncyc + (((op != 0) && (op <= 8'h04)) ? LAT + 1 : 1);
      q.push_back(e);
      last_win = id;
      l_op = op; l_a = a; l_b = b;
      if (id) gcnt1++; else gcnt0++;
   endtask

   // Stimulus side: every handshake pushes its expected response.
   always @(posedge sys_clk) begin
      if (!sys_rst) begin
         if (req0_valid && req0_ready) push(1'b0, req0_op, req0_a, req0_b);
         if (req1_valid && req1_ready) push(1'b1, req1_op, req1_a, req1_b);
      end
   end

   // Monitor: grant rule, ALU drive, response timing/data, counters.
   always @(negedge sys_clk) begin
      logic pend, e_win, e_acc;
      ncyc++;
      if (sys_rst) begin
         chk("rst_ready0", req0_ready, 0);
         chk("rst_ready1", req1_ready, 0);
         chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
         chk("rst_rsp", {rsp_valid, rsp_data, rsp_id, busy}, 0);
         q.delete();
         last_win = 1'b1;
         l_op = 0; l_a = 0; l_b = 0;
         gcnt0 = 0; gcnt1 = 0;
      end else begin
         pend  = (q.size() != 0);
         e_win = (req0_valid && req1_valid) ? ~last_win : req1_valid;
         e_acc = !pend && (req0_valid || req1_valid);
         chk("ready0", req0_ready, e_acc && !e_win);
         chk("ready1", req1_ready, e_acc && e_win);
         chk("busy", busy, pend);
         chk("alu_drive", {alu_op, alu_a, alu_b}, {l_op, l_a, l_b});
         if (pend) begin
            chk("rsp_valid", rsp_valid, ncyc >= q[0].due);
            if (rsp_valid) begin
               chk("rsp_data", rsp_data, q[0].data);
               chk("rsp_id", rsp_id, q[0].id);
               if (rsp_ready) void'(q.pop_front());
            end
         end else begin
            chk("rsp_idle", rsp_valid, 0);
         end
      end
`ifdef D8_ALU_SCHED_STATS_EN
      chk("grant_cnt0", grant_cnt0, (gcnt0 > 3) ? 3 : gcnt0);
      chk("grant_cnt1", grant_cnt1, (gcnt1 > 3) ? 3 : gcnt1);
`endif
   end

   task automatic set_in(logic v0, logic [7:0] op0, a0, b0,
                         logic v1, logic [7:0] op1, a1, b1, logic rr);
      @(posedge sys_clk); #1;
      req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
      rsp_ready = rr;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   function automatic logic [7:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 8'h01;
         1: return 8'h02;
         2: return 8'h03;
         3: return 8'h04;
         4: return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int n;
      sys_rst = 1'b1;
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      rsp_ready = 1;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b0;

      // ALU add, then bypass from requester 1
      set_in(1, 8'h01, 8'h03, 8'h05, 0, 0, 0, 0, 1);
      idle(LAT + 3);
      set_in(0, 0, 0, 0, 1, 8'h10, 8'hFF, 8'hAA, 1);
      idle(3);

      // contention: grants alternate
      for (int i = 0; i < 6 * (LAT + 2); i++)
         set_in(1, 8'h03, 8'($urandom), 8'($urandom), 1, 8'h03, 8'($urandom), 8'($urandom), 1);
      idle(LAT + 3);

      // consumer stalls with a response pending
      set_in(1, 8'h00, 8'h11, 8'h22, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) set_in(1, 8'h01, 1, 2, 1, 8'h02, 3, 4, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(3);

      // reset in the middle of EXEC
      set_in(1, 8'h02, 8'h09, 8'h04, 0, 0, 0, 0, 1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      n = 0;
      while (!busy && n < 20) begin @(posedge sys_clk); n++; end
      chk("exec_reached", busy, 1);
      sys_rst = 1'b1;
      #1;
      chk("async_rst_out", {alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_id, busy}, 0);
      @(posedge sys_clk); #1 sys_rst = 1'b0;
      set_in(1, 8'h04, 8'hF0, 8'h0F, 0, 0, 0, 0, 1);
      idle(LAT + 3);

      // randomized traffic
      for (int i = 0; i < 2000; i++)
         set_in($urandom_range(0, 2) != 0, rnd_op(), 8'($urandom), 8'($urandom),
                $urandom_range(0, 2) != 0, rnd_op(), 8'($urandom), 8'($urandom),
                $urandom_range(0, 3) != 0);

`ifdef D8_ALU_SCHED_STATS_EN
      // saturation: five grants to requester 0 after a fresh reset
      @(posedge sys_clk); #1 sys_rst = 1'b1;
      @(posedge sys_clk); #1 sys_rst = 1'b0;
      for (int i = 0; i < 10; i++) set_in(1, 8'h07, 1, 2, 0, 0, 0, 0, 1);
      idle(2);
      chk("stat_grants0", gcnt0, 5);
      chk("stat_sat0", grant_cnt0, 3);
      chk("stat_cnt1", grant_cnt1, 0);
`endif

      // drain within a bounded window
      n = 0;
      while (q.size() != 0 && n < 50) begin idle(1); n++; end
      chk("drain", q.size(), 0);
      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
